display_scan_mux: RTL and testbench



---
 rtl/display_pkg.sv | 18 +
 rtl/display_scan_mux_prescaler.sv | 30 +++
 rtl/display_scan_mux.sv | 122 ++++++++++++
 tb/tb_display_scan_mux.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared helpers for the display scan multiplexer.
//   sel_width(n) : max(1, clog2(n)), width of an index/counter over n values
//   AN_OFF       : all-ones (every digit dark) anode pattern, slice to DIGITS
//   digit_lsb()  : LSB position of digit idx in a packed digit bus
package display_pkg;

  localparam int MAX_DIGITS = 16;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int digit_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/display_scan_mux_prescaler.sv
// scan_prescaler: free-running 0..DIV-1 counter gated by en.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : count enable; holds the count when low
//   tick : high in the last cycle of each DIV-cycle step (combinational)
module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = sel_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed seven-segment digit scanner.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   en          : scan enable; low freezes scanning and blanks the display
//   digits_in   : DIGITS packed codes, digit i at [i*WIDTH +: WIDTH]
//   blink_mask  : per-digit blink request
//   sel         : index of the digit currently being scanned
//   an          : one-hot active-low digit enable (registered)
//   bcd         : code of the current digit (registered)
//   frame_start : one-cycle pulse in the first cycle sel reads 0 after a wrap
// Optional feature macro: DISPLAY_SCAN_BLINK_EN (blink counter and phase;
// without it blink_mask is ignored).
module display_scan_mux
  import display_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int WIDTH        = 4,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64,
  localparam int SELW        = sel_width(DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIGITS*WIDTH-1:0] digits_in,
  input  logic [DIGITS-1:0]       blink_mask,
  output logic [SELW-1:0]         sel,
  output logic [DIGITS-1:0]       an,
  output logic [WIDTH-1:0]        bcd,
  output logic                    frame_start
);

  localparam logic [SELW-1:0] SEL_LAST = SELW'(DIGITS - 1);

  logic                    tick;
  logic                    wrap;
  logic [DIGITS*WIDTH-1:0] shadow;
  logic [WIDTH-1:0]        cur_code;
  logic [DIGITS-1:0]       cur_onehot;
  logic                    blank_now;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign wrap = tick && (sel == SEL_LAST);

  // sel counter and frame snapshot; the shadow only ever changes on a wrap
  // so a frame always shows one consistent set of digit values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap) begin
        sel    <= '0;
        shadow <= digits_in;
      end else if (tick) begin
        sel    <= sel + SELW'(1);
      end
    end
  end

  // Digit mux written as a compare loop so out-of-range sel codes
  // (non-power-of-two DIGITS) simply select nothing.
  always_comb begin
    cur_code   = '0;
    cur_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel == SELW'(i)) begin
        cur_code      = shadow[digit_lsb(i, WIDTH) +: WIDTH];
        cur_onehot[i] = 1'b1;
      end
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int BCW = sel_width(BLINK_FRAMES);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  // Counts frame wraps; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BCW'(1);
      end
    end
  end

  assign blank_now = blink_phase && |(blink_mask & cur_onehot);
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blank_now    = 1'b0;
`endif

  // Output register: one cycle behind sel.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      an  <= AN_OFF[DIGITS-1:0];
      bcd <= '0;
    end else begin
      bcd <= cur_code;
      an  <= blank_now ? AN_OFF[DIGITS-1:0] : ~cur_onehot;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: randomized self-checking bench for display_scan_mux.
// The reference model tracks only the number of enabled cycles since reset
// and derives sel, frame number and blink phase from it arithmetically.
module tb_display_scan_mux;

  localparam int DIGITS = 6;
  localparam int WIDTH  = 4;
  localparam int DIV    = 4;
  localparam int BF     = 2;
  localparam int SELW   = 3;
  localparam int FRAME  = DIGITS * DIV;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic [DIGITS*WIDTH-1:0] digits_in;
  logic [DIGITS-1:0]       blink_mask;
  logic [SELW-1:0]         sel;
  logic [DIGITS-1:0]       an;
  logic [WIDTH-1:0]        bcd;
  logic                    frame_start;

  display_scan_mux #(
    .DIGITS(DIGITS), .WIDTH(WIDTH), .DIV(DIV), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in),
    .blink_mask(blink_mask), .sel(sel), .an(an), .bcd(bcd),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state
  int   t;                 // enabled cycles since reset
  int   shadow_m [DIGITS];
  logic [DIGITS-1:0] exp_an;
  int   exp_bcd;
  bit   exp_fs;
  bit   model_valid = 0;

  function automatic int m_sel(input int tt);
    return (tt / DIV) % DIGITS;
  endfunction

  function automatic bit m_phase(input int tt);
`ifdef DISPLAY_SCAN_BLINK_EN
    return ((tt / FRAME) / BF) % 2 == 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    int  s;
    bit  tk;
    if (rst) begin
      t = 0;
      foreach (shadow_m[i]) shadow_m[i] = 0;
      exp_an = '1; exp_bcd = 0; exp_fs = 0;
      model_valid = 1;
      return;
    end
    s = m_sel(t);
    if (!en) begin
      exp_an = '1; exp_bcd = 0;
    end else begin
      exp_bcd = shadow_m[s];
      if (m_phase(t) && blink_mask[s]) exp_an = '1;
      else exp_an = ~(DIGITS'(1) << s);
    end
    tk = en && (t % DIV == DIV - 1);
    exp_fs = tk && (s == DIGITS - 1);
    if (exp_fs)
      for (int i = 0; i < DIGITS; i++) shadow_m[i] = int'(digits_in[i*WIDTH +: WIDTH]);
    if (en) t++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (model_valid) begin
      chk("sel", 32'(sel), 32'(m_sel(t)));
      chk("an", 32'(an), 32'(exp_an));
      chk("bcd", 32'(bcd), 32'(exp_bcd));
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; digits_in = 24'h543210; blink_mask = '0;
    repeat (3) cycle();
    // reset state against constants
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_an", 32'(an), 32'h3f);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);

    // Directed: plain scan over three frames, first tick after DIV cycles
    rst = 1'b0; en = 1'b1;
    repeat (DIV) cycle();
    chk("first_step_sel", 32'(sel), 32'd1);
    repeat (3 * FRAME) cycle();

    // Mid-frame digits change, then an en=0 gap mid-digit
    while (sel != 3) cycle();
    digits_in = 24'h999999;
    repeat (FRAME + 6) cycle();
    en = 1'b0;
    repeat (10) cycle();
    chk("en_off_an", 32'(an), 32'h3f);
    en = 1'b1;
    repeat (FRAME) cycle();

    // Reset while sel=4
    while (sel != 4) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_an", 32'(an), 32'h3f);

    // Blink mask over several frames
    blink_mask = 6'b000011;
    repeat (6 * FRAME) cycle();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) digits_in = 24'($urandom);
      if ($urandom_range(0, 59) == 0) blink_mask = 6'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
